// File: rtl/risc_test_sequencer.sv
// Load/clear/run harness for the 16-bit RISC core: streams images into instr/data memory, runs to HLT or timeout, queues OutR results.
// Load strobes are registered (1-cycle latency, ld_ready low in CLEAR/RUN); results pop on out_valid&out_ready. Option: RISC_SEQ_TIMESTAMP_EN adds out_stamp_o.

module risc_seq_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 8
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic [W-1:0] dat_i,
   input  logic         pop_i,
   output logic [W-1:0] dat_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_q;
   logic [PW-1:0] wr_q;
   logic [PW:0]   cnt_q;
   logic          do_pop;
   logic          do_push;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || do_pop);
   assign dat_o   = mem_q[rd_q];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_q] <= dat_i;
   end
endmodule

module risc_test_sequencer #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int OUT_DEPTH   = 8,
   parameter int CYC_W       = 16,
   parameter int RUN_TIMEOUT = 1024,
   parameter int CLR_CYCLES  = 2
) (
   input  logic              clk_i,
   input  logic              clr_n_i,
   input  logic              ld_valid_i,
   output logic              ld_ready_o,
   input  logic              ld_target_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [DATA_W-1:0] ld_data_i,
   input  logic              ld_last_i,
   input  logic              start_i,
   output logic              test_normal_o,
   output logic              ext_instr_we_o,
   output logic [ADDR_W-1:0] ext_instr_addr_o,
   output logic [DATA_W-1:0] ext_instr_data_o,
   output logic              ext_data_write_en_o,
   output logic [ADDR_W-1:0] ext_data_addr_o,
   output logic [DATA_W-1:0] ext_data_data_o,
   output logic              core_clr_o,
   input  logic              core_halt_i,
   input  logic              outr_strobe_i,
   input  logic [DATA_W-1:0] outr_in_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
`ifdef RISC_SEQ_TIMESTAMP_EN
   output logic [CYC_W-1:0]  out_stamp_o,
`endif
   output logic              busy_o,
   output logic              done_o,
   output logic              timeout_o,
   output logic              overflow_o,
   output logic [CYC_W-1:0]  run_cycles_o
);
   localparam int CW = $clog2(CLR_CYCLES + 1);
`ifdef RISC_SEQ_TIMESTAMP_EN
   localparam int FW = DATA_W + CYC_W;
`else
   localparam int FW = DATA_W;
`endif

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARMED, S_CLEAR, S_RUN, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
   logic [CYC_W-1:0]  run_cycles_q, run_cycles_d;
   logic [CYC_W-1:0]  run_inc;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;
   logic              overflow_q, overflow_d;
   logic              ext_instr_we_q, ext_data_we_q;
   logic [ADDR_W-1:0] ext_instr_addr_q, ext_data_addr_q;
   logic [DATA_W-1:0] ext_instr_data_q, ext_data_data_q;
   logic              accept, clr_entry, in_run, hit_timeout;
   logic              push_req, pop, fifo_full, fifo_empty;
   logic [FW-1:0]     fifo_in, fifo_out;

   assign accept      = ld_valid_i && ld_ready_o;
   assign in_run      = (state_q == S_RUN);
   assign run_inc     = run_cycles_q + 1'b1;
   assign hit_timeout = (run_inc == CYC_W'(RUN_TIMEOUT));
   assign clr_entry   = (state_d == S_CLEAR) && (state_q != S_CLEAR);
   assign push_req    = in_run && outr_strobe_i;
   assign pop         = out_valid_o && out_ready_i;

   always_ff @(posedge clk_i or negedge clr_n_i) begin
      if (!clr_n_i) begin
         state_q      <= S_IDLE;
         clr_cnt_q    <= '0;
         run_cycles_q <= '0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         run_cycles_q <= run_cycles_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         overflow_q   <= overflow_d;
      end
   end

   // A load beat outranks start, so a re-load can never be raced by a run.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_ARMED, S_DONE: begin
            if (accept)       state_d = ld_last_i ? S_ARMED : S_LOAD;
            else if (start_i) state_d = S_CLEAR;
         end
         S_LOAD:  if (accept) state_d = ld_last_i ? S_ARMED : S_LOAD;
         S_CLEAR: if (clr_cnt_q == CW'(CLR_CYCLES - 1)) state_d = S_RUN;
         S_RUN:   if (core_halt_i || hit_timeout) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ld_ready_o    = 1'b0;
      test_normal_o = 1'b1;
      core_clr_o    = 1'b0;
      busy_o        = 1'b0;
      case (state_q)
         S_IDLE, S_ARMED, S_DONE: ld_ready_o = 1'b1;
         S_LOAD: begin
            ld_ready_o = 1'b1;
            busy_o     = 1'b1;
         end
         S_CLEAR: begin
            test_normal_o = 1'b0;
            core_clr_o    = 1'b1;
            busy_o        = 1'b1;
         end
         S_RUN: begin
            test_normal_o = 1'b0;
            busy_o        = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      clr_cnt_d    = (state_q == S_CLEAR) ? clr_cnt_q + 1'b1 : '0;
      run_cycles_d = run_cycles_q;
      done_d       = done_q;
      timeout_d    = timeout_q;
      overflow_d   = overflow_q;
      if (clr_entry) begin
         run_cycles_d = '0;
         done_d       = 1'b0;
         timeout_d    = 1'b0;
         overflow_d   = 1'b0;
      end else begin
         if (in_run) run_cycles_d = run_inc;
         if (in_run && (state_d == S_DONE)) done_d = 1'b1;
         if (in_run && !core_halt_i && hit_timeout) timeout_d = 1'b1;
         if (push_req && fifo_full && !pop) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge clr_n_i) begin
      if (!clr_n_i) begin
         ext_instr_we_q   <= 1'b0;
         ext_data_we_q    <= 1'b0;
         ext_instr_addr_q <= '0;
         ext_instr_data_q <= '0;
         ext_data_addr_q  <= '0;
         ext_data_data_q  <= '0;
      end else begin
         ext_instr_we_q <= accept && !ld_target_i;
         ext_data_we_q  <= accept && ld_target_i;
         if (accept && !ld_target_i) begin
            ext_instr_addr_q <= ld_addr_i;
            ext_instr_data_q <= ld_data_i;
         end
         if (accept && ld_target_i) begin
            ext_data_addr_q <= ld_addr_i;
            ext_data_data_q <= ld_data_i;
         end
      end
   end

   assign ext_instr_we_o      = ext_instr_we_q;
   assign ext_instr_addr_o    = ext_instr_addr_q;
   assign ext_instr_data_o    = ext_instr_data_q;
   assign ext_data_write_en_o = ext_data_we_q;
   assign ext_data_addr_o     = ext_data_addr_q;
   assign ext_data_data_o     = ext_data_data_q;

`ifdef RISC_SEQ_TIMESTAMP_EN
   // Stamp is the cycle count before this RUN cycle's increment.
   assign fifo_in     = {run_cycles_q, outr_in_i};
   assign out_stamp_o = fifo_out[FW-1:DATA_W];
`else
   assign fifo_in     = outr_in_i;
`endif
   assign out_data_o  = fifo_out[DATA_W-1:0];
   assign out_valid_o = !fifo_empty;

   risc_seq_fifo #(.W(FW), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .clk_i   (clk_i),
      .rst_n_i (clr_n_i),
      .flush_i (clr_entry),
      .push_i  (push_req),
      .dat_i   (fifo_in),
      .pop_i   (pop),
      .dat_o   (fifo_out),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign done_o       = done_q;
   assign timeout_o    = timeout_q;
   assign overflow_o   = overflow_q;
   assign run_cycles_o = run_cycles_q;
endmodule

// File: tb/tb_risc_test_sequencer.sv
// Directed bench for risc_test_sequencer: stimulus queues expected OutR results, a negedge monitor pops and compares them.
module tb_risc_test_sequencer;
   logic        clk_i = 1'b0;
   logic        clr_n_i = 1'b1;
   logic        ld_valid_i = 1'b0, ld_target_i = 1'b0, ld_last_i = 1'b0, start_i = 1'b0;
   logic [15:0] ld_addr_i = '0, ld_data_i = '0, outr_in_i = '0;
   logic        core_halt_i = 1'b0, outr_strobe_i = 1'b0, out_ready_i = 1'b0;
   logic        ld_ready_o, test_normal_o, ext_instr_we_o, ext_data_write_en_o, core_clr_o;
   logic [15:0] ext_instr_addr_o, ext_instr_data_o, ext_data_addr_o, ext_data_data_o, out_data_o;
   logic        out_valid_o, busy_o, done_o, timeout_o, overflow_o;
   logic [15:0] run_cycles_o;

   int          n_chk = 0;
   int          n_bad = 0;
   logic [15:0] exp_q[$];
   int          str_cyc[$];
   logic [15:0] str_dat[$];
   bit          str_keep[$];

   risc_test_sequencer #(
      .DATA_W(16), .ADDR_W(16), .OUT_DEPTH(4), .CYC_W(16), .RUN_TIMEOUT(16), .CLR_CYCLES(2)
   ) dut (
      .clk_i(clk_i), .clr_n_i(clr_n_i),
      .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_target_i(ld_target_i),
      .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i), .ld_last_i(ld_last_i), .start_i(start_i),
      .test_normal_o(test_normal_o),
      .ext_instr_we_o(ext_instr_we_o), .ext_instr_addr_o(ext_instr_addr_o), .ext_instr_data_o(ext_instr_data_o),
      .ext_data_write_en_o(ext_data_write_en_o), .ext_data_addr_o(ext_data_addr_o), .ext_data_data_o(ext_data_data_o),
      .core_clr_o(core_clr_o), .core_halt_i(core_halt_i), .outr_strobe_i(outr_strobe_i), .outr_in_i(outr_in_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .overflow_o(overflow_o),
      .run_cycles_o(run_cycles_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (clr_n_i && out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL out_unexpected: got 0x%0h expected no output", out_data_o);
         end else begin
            chk("out_data", out_data_o, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic neg();
      @(negedge clk_i);
   endtask

   task automatic beat(input logic tgt, input logic [15:0] a, input logic [15:0] d, input logic last);
      ld_valid_i = 1'b1; ld_target_i = tgt; ld_addr_i = a; ld_data_i = d; ld_last_i = last;
      tick();
      ld_valid_i = 1'b0; ld_last_i = 1'b0;
   endtask

   task automatic start_run();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         neg();
         chk("clear_core_clr", core_clr_o, 1);
         chk("clear_test_normal", test_normal_o, 0);
         tick();
      end
      neg();
      chk("run_core_clr", core_clr_o, 0);
      chk("run_entry_cycles", run_cycles_o, 0);
      chk("run_entry_status", {done_o, timeout_o, overflow_o}, 0);
   endtask

   task automatic run_core(input int halt_at, input int ncyc, input logic rdy_base, input int rdy_at);
      for (int c = 1; c <= ncyc; c++) begin
         core_halt_i   = (c == halt_at);
         out_ready_i   = (c == rdy_at) ? 1'b1 : rdy_base;
         outr_strobe_i = 1'b0;
         if (str_cyc.size() > 0 && str_cyc[0] == c) begin
            outr_strobe_i = 1'b1;
            outr_in_i     = str_dat[0];
            if (str_keep[0]) exp_q.push_back(str_dat[0]);
            str_cyc.delete(0); str_dat.delete(0); str_keep.delete(0);
         end
         tick();
      end
      core_halt_i = 1'b0; outr_strobe_i = 1'b0; out_ready_i = rdy_base;
   endtask

   task automatic drain(input string name);
      out_ready_i = 1'b1;
      repeat (6) tick();
      neg();
      chk({name, "_empty"}, out_valid_o, 0);
      chk({name, "_left"}, exp_q.size(), 0);
      out_ready_i = 1'b0;
   endtask

   initial begin
      #100000;
      n_bad++;
      $display("FAIL watchdog: got no finish expected finish");
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $fatal(1);
   end

   initial begin
      #2 clr_n_i = 1'b0;
      neg();
      chk("rst_ld_ready", ld_ready_o, 1);
      chk("rst_test_normal", test_normal_o, 1);
      chk("rst_ctrl", {core_clr_o, busy_o, done_o, timeout_o, overflow_o, out_valid_o}, 0);
      chk("rst_strobes", {ext_instr_we_o, ext_data_write_en_o}, 0);
      chk("rst_ext", {ext_instr_addr_o, ext_data_data_o}, 0);
      chk("rst_run_cycles", run_cycles_o, 0);
      tick();
      clr_n_i = 1'b1;
      tick();

      // Load instr 0x1900 then data 0x0012 (last).
      beat(1'b0, 16'h0000, 16'h1900, 1'b0);
      neg();
      chk("ld1_instr_we", ext_instr_we_o, 1);
      chk("ld1_data_we", ext_data_write_en_o, 0);
      chk("ld1_instr", {ext_instr_addr_o, ext_instr_data_o}, 32'h0000_1900);
      chk("ld1_busy_load", busy_o, 1);
      beat(1'b1, 16'h0000, 16'h0012, 1'b1);
      neg();
      chk("ld2_instr_we", ext_instr_we_o, 0);
      chk("ld2_data_we", ext_data_write_en_o, 1);
      chk("ld2_data", {ext_data_addr_o, ext_data_data_o}, 32'h0000_0012);
      chk("ld2_armed", {busy_o, ld_ready_o, test_normal_o}, 3'b011);
      tick();
      neg();
      chk("ld2_we_one_cycle", ext_data_write_en_o, 0);

      // Run: strobes at cycles 2 and 4, halt in cycle 5.
      out_ready_i = 1'b1;
      str_cyc = '{2, 4}; str_dat = '{16'h0012, 16'h1234}; str_keep = '{1, 1};
      start_run();
      run_core(5, 5, 1'b1, 0);
      neg();
      chk("run_done", {done_o, timeout_o}, 2'b10);
      chk("run_cycles", run_cycles_o, 5);
      chk("run_done_status", {test_normal_o, busy_o}, 2'b10);
      tick();
      neg();
      chk("run_cycles_frozen", run_cycles_o, 5);
      drain("run_drain");

      // Timeout at 16 RUN cycles with no halt.
      start_run();
      run_core(0, 15, 1'b0, 0);
      neg();
      chk("to_still_run", {busy_o, done_o}, 2'b10);
      chk("to_cycles15", run_cycles_o, 15);
      run_core(0, 1, 1'b0, 0);
      neg();
      chk("to_flags", {done_o, timeout_o, test_normal_o}, 3'b111);
      chk("to_cycles16", run_cycles_o, 16);

      // Overflow: 6 strobes into a 4-deep FIFO with no reader.
      for (int i = 0; i < 6; i++) begin
         str_cyc.push_back(i + 1); str_dat.push_back(16'hA000 + 16'(i)); str_keep.push_back(i < 4);
      end
      start_run();
      run_core(7, 7, 1'b0, 0);
      neg();
      chk("ovf_flag", overflow_o, 1);
      chk("ovf_head", out_data_o, 16'hA000);
      drain("ovf_drain");

      // Full FIFO with simultaneous push and pop.
      for (int i = 0; i < 5; i++) begin
         str_cyc.push_back(i + 1); str_dat.push_back(16'hB000 + 16'(i)); str_keep.push_back(1'b1);
      end
      start_run();
      run_core(6, 6, 1'b0, 5);
      neg();
      chk("pp_no_overflow", overflow_o, 0);
      chk("pp_done", done_o, 1);
      drain("pp_drain");

      // Load from DONE, then ld_valid and start together in ARMED.
      beat(1'b0, 16'h0010, 16'h1111, 1'b1);
      neg();
      chk("rl_armed", {busy_o, ld_ready_o, ext_instr_we_o}, 3'b011);
      start_i = 1'b1;
      beat(1'b0, 16'h0011, 16'h2222, 1'b0);
      start_i = 1'b0;
      neg();
      chk("prio_no_clr", {core_clr_o, test_normal_o}, 2'b01);
      chk("prio_load", {busy_o, ext_instr_we_o}, 2'b11);
      chk("prio_instr", {ext_instr_addr_o, ext_instr_data_o}, 32'h0011_2222);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      neg();
      chk("load_ignores_start", {core_clr_o, busy_o, ld_ready_o}, 3'b011);
      beat(1'b1, 16'h0020, 16'h3333, 1'b1);
      neg();
      chk("prio_data", {ext_data_write_en_o, ext_data_data_o}, {1'b1, 16'h3333});

      // Reset in the middle of a run.
      str_cyc = '{1}; str_dat = '{16'hC000}; str_keep = '{0};
      start_run();
      run_core(0, 3, 1'b0, 0);
      neg();
      chk("mid_run_busy", {busy_o, out_valid_o}, 2'b11);
      tick();
      clr_n_i = 1'b0;
      neg();
      chk("mrst_idle", {test_normal_o, ld_ready_o, busy_o, core_clr_o}, 4'b1100);
      chk("mrst_fifo", out_valid_o, 0);
      chk("mrst_cycles", run_cycles_o, 0);
      tick();
      clr_n_i = 1'b1;
      tick();
      neg();
      chk("mrst_after", {test_normal_o, busy_o, done_o}, 3'b100);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
